// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between the
// CPU load/store port (0) and the loader/DMA port (1). Every access walks
// through IDLE -> ACCESS -> DONE and is acknowledged with a one-cycle pulse.
module dmem_arbiter #(
    parameter int DEPTH         = 64,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData,
    output logic        busy
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    state_t        nextState;
    logic          lastGrant;
    logic          curPort;
    logic          curWe;
    logic [31:0]   curAddr;
    logic [31:0]   curWdata;
    logic [CW-1:0] cnt;
    logic          grantValid;
    logic          grantPort;
    logic          inRange;

    // Addresses are compared in full; upper bits are never masked off
    assign inRange = (curAddr < 32'(DEPTH));

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state, grant decision and all memory/handshake outputs
    always_comb begin
        nextState  = state;
        grantValid = 1'b0;
        grantPort  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = '0;
        WriteData  = '0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        err0       = 1'b0;
        err1       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                grantValid = req0 | req1;
                if (req0 && req1) begin
                    grantPort = ~lastGrant;
                end else begin
                    grantPort = req1;
                end
                if (grantValid) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                Address   = curAddr;
                WriteData = curWdata;
                if (inRange) begin
                    MemRead  = ~curWe;
                    MemWrite = curWe && (cnt == '0);
                end
                if (cnt == '0) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                ack0      = ~curPort;
                ack1      = curPort;
                err0      = ~curPort & ~inRange;
                err1      = curPort & ~inRange;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Request latch, access counter, read-data capture and fairness pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGrant <= 1'b1;
            curPort   <= 1'b0;
            curWe     <= 1'b0;
            curAddr   <= '0;
            curWdata  <= '0;
            cnt       <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        curPort  <= grantPort;
                        curWe    <= grantPort ? we1 : we0;
                        curAddr  <= grantPort ? addr1 : addr0;
                        curWdata <= grantPort ? wdata1 : wdata0;
                        cnt      <= CW'(ACCESS_CYCLES - 1);
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!curWe) begin
                        if (curPort) begin
                            rdata1 <= inRange ? ReadData : '0;
                        end else begin
                            rdata0 <= inRange ? ReadData : '0;
                        end
                    end
                end
                DONE: begin
                    lastGrant <= curPort;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
